// File: rtl/iic_master_rr_arbiter.sv
// Round-robin arbiter that shares one IIC master between C_CH_NUM requesters.
// Optional watchdog enabled by defining IIC_ARB_TIMEOUT_EN.
module iic_master_rr_arbiter #(
    parameter int unsigned C_CH_NUM      = 4,
    parameter int unsigned C_TIMEOUT_CYC = 1000000
) (
    input  logic                    CLK_I,
    input  logic                    RST_N_I,
    // requester side
    input  logic [C_CH_NUM-1:0]     START_I,
    input  logic [8*C_CH_NUM-1:0]   WR_BYTE_NUM_I,
    input  logic [64*C_CH_NUM-1:0]  WR_DATA_I,
    input  logic [8*C_CH_NUM-1:0]   RD_BYTE_NUM_I,
    output logic [C_CH_NUM-1:0]     BUSY_O,
    output logic [C_CH_NUM-1:0]     FINISH_O,
    output logic [C_CH_NUM-1:0]     ERROR_O,
    output logic [63:0]             RD_DATA_O,
    output logic [C_CH_NUM-1:0]     GNT_O,
    // master side
    output logic [7:0]              WR_BYTE_NUM_O,
    output logic [63:0]             WR_DATA_O,
    output logic [7:0]              RD_BYTE_NUM_O,
    output logic                    START_O,
    input  logic [63:0]             RD_DATA_I,
    input  logic                    BUSY_I,
    input  logic                    FINISH_I,
    input  logic                    ERROR_I
);

    localparam int unsigned IDX_W = $clog2(C_CH_NUM);

    if (C_CH_NUM < 2 || C_CH_NUM > 8 || C_TIMEOUT_CYC < 4) begin : g_param_check
        $error("iic_master_rr_arbiter: illegal C_CH_NUM or C_TIMEOUT_CYC");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RELEASE
    } state_t;

    state_t              state;
    logic [C_CH_NUM-1:0] pend;
    logic [C_CH_NUM-1:0] busy_reg;
    logic [C_CH_NUM-1:0] accept;
    logic [IDX_W-1:0]    last_gnt;
    logic [IDX_W-1:0]    gnt_idx;
    logic [IDX_W-1:0]    rr_idx;
    logic [IDX_W-1:0]    cand;
    logic                rr_found;

    logic [7:0]          wr_num_buf [C_CH_NUM];
    logic [63:0]         wr_data_buf[C_CH_NUM];
    logic [7:0]          rd_num_buf [C_CH_NUM];

`ifdef IIC_ARB_TIMEOUT_EN
    logic [31:0]         to_cnt;
`endif

    assign accept = START_I & ~busy_reg;
    assign BUSY_O = busy_reg | START_I;

    // Walk from the farthest candidate down to last_gnt+1 so the nearest pending channel wins.
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = C_CH_NUM; k >= 1; k--) begin
            cand = IDX_W'((int'(last_gnt) + k) % C_CH_NUM);
            if (pend[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; later assignments in the block take priority.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state         <= S_IDLE;
            pend          <= '0;
            busy_reg      <= '0;
            last_gnt      <= IDX_W'(C_CH_NUM - 1);
            gnt_idx       <= '0;
            // NOTE: the request buffers are small register arrays and are reset like any other state.
            for (int c = 0; c < C_CH_NUM; c++) begin
                wr_num_buf[c]  <= '0;
                wr_data_buf[c] <= '0;
                rd_num_buf[c]  <= '0;
            end
            FINISH_O      <= '0;
            ERROR_O       <= '0;
            RD_DATA_O     <= '0;
            GNT_O         <= '0;
            WR_BYTE_NUM_O <= '0;
            WR_DATA_O     <= '0;
            RD_BYTE_NUM_O <= '0;
            START_O       <= 1'b0;
`ifdef IIC_ARB_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            FINISH_O <= '0;
            ERROR_O  <= '0;

            for (int c = 0; c < C_CH_NUM; c++) begin
                if (accept[c]) begin
                    pend[c]        <= 1'b1;
                    busy_reg[c]    <= 1'b1;
                    wr_num_buf[c]  <= WR_BYTE_NUM_I[c*8 +: 8];
                    wr_data_buf[c] <= WR_DATA_I[c*64 +: 64];
                    rd_num_buf[c]  <= RD_BYTE_NUM_I[c*8 +: 8];
                end
            end

            case (state)
                S_IDLE: begin
                    if (rr_found) begin
                        gnt_idx       <= rr_idx;
                        GNT_O         <= C_CH_NUM'(1) << rr_idx;
                        WR_BYTE_NUM_O <= wr_num_buf[rr_idx];
                        WR_DATA_O     <= wr_data_buf[rr_idx];
                        RD_BYTE_NUM_O <= rd_num_buf[rr_idx];
                        START_O       <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    START_O       <= 1'b0;
                    pend[gnt_idx] <= 1'b0;
                    last_gnt      <= gnt_idx;
                    state         <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // A master that finishes without ever raising BUSY_I is still completed here.
                    if (FINISH_I) begin
                        RD_DATA_O         <= RD_DATA_I;
                        FINISH_O[gnt_idx] <= 1'b1;
                        ERROR_O[gnt_idx]  <= ERROR_I;
                        state             <= S_RELEASE;
                    end else if (BUSY_I) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (FINISH_I) begin
                        RD_DATA_O         <= RD_DATA_I;
                        FINISH_O[gnt_idx] <= 1'b1;
                        ERROR_O[gnt_idx]  <= ERROR_I;
                        state             <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!BUSY_I) begin
                        busy_reg[gnt_idx] <= 1'b0;
                        GNT_O             <= '0;
                        WR_BYTE_NUM_O     <= '0;
                        WR_DATA_O         <= '0;
                        RD_BYTE_NUM_O     <= '0;
                        state             <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

`ifdef IIC_ARB_TIMEOUT_EN
            // Watchdog overrides whatever the master is doing and frees the channel with an error.
            if (state inside {S_WAIT_BUSY, S_WAIT_DONE, S_RELEASE}) begin
                if (to_cnt >= C_TIMEOUT_CYC - 1) begin
                    FINISH_O[gnt_idx] <= 1'b1;
                    ERROR_O[gnt_idx]  <= 1'b1;
                    busy_reg[gnt_idx] <= 1'b0;
                    GNT_O             <= '0;
                    WR_BYTE_NUM_O     <= '0;
                    WR_DATA_O         <= '0;
                    RD_BYTE_NUM_O     <= '0;
                    to_cnt            <= '0;
                    state             <= S_IDLE;
                end else begin
                    to_cnt <= to_cnt + 32'd1;
                end
            end else begin
                to_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: doc/iic_master_rr_arbiter.md
IIC_MASTER_RR_ARBITER -- requirements
Module: iic_master_rr_arbiter

Interface
REQ-001 The block SHALL have parameter C_CH_NUM, default 4, number of requesters (legal 2..8).
REQ-002 The block SHALL have parameter C_TIMEOUT_CYC, default 1000000, watchdog limit in CLK_I cycles (32-bit, >=4).
REQ-003 The block SHALL have a single clock and an asynchronous active-low reset: CLK_I in 1 clock; RST_N_I in 1 reset.
REQ-004 Requester ports SHALL be:
- START_I in C_CH_NUM, per-channel request pulse
- WR_BYTE_NUM_I in 8*C_CH_NUM, packed
- WR_DATA_I in 64*C_CH_NUM, packed
- RD_BYTE_NUM_I in 8*C_CH_NUM, packed
- BUSY_O out C_CH_NUM, channel occupied
- FINISH_O out C_CH_NUM, done pulse
- ERROR_O out C_CH_NUM, error pulse
- RD_DATA_O out 64, shared read data, valid with FINISH_O
- GNT_O out C_CH_NUM, one-hot current owner
REQ-005 Master-side ports SHALL be:
- WR_BYTE_NUM_O out 8
- WR_DATA_O out 64
- RD_BYTE_NUM_O out 8
- START_O out 1
- RD_DATA_I in 64
- BUSY_I in 1
- FINISH_I in 1
- ERROR_I in 1

Function
REQ-006 START_I[c] sampled while BUSY_O[c]=0 SHALL capture channel c fields into buffer c and set pend[c]; while BUSY_O[c]=1 it SHALL be ignored.
REQ-007 BUSY_O[c] SHALL equal busy_reg[c] OR START_I[c]; busy_reg[c] sets on an accepted START_I[c] and clears on leaving RELEASE or on timeout for c.
REQ-008 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RELEASE.
REQ-009 IDLE: if any pend set, grant the first pending channel searching upward (with wrap) from last_gnt+1, load its fields into output registers, set GNT_O, go ISSUE; else stay.
REQ-010 ISSUE: START_O=1 for exactly one cycle, clear pend[g], record last_gnt=g, go WAIT_BUSY.
REQ-011 WAIT_BUSY: go WAIT_DONE when BUSY_I=1 or FINISH_I=1 (FINISH_I handled as in REQ-012 in the same cycle).
REQ-012 WAIT_DONE: on FINISH_I=1, register RD_DATA_O<=RD_DATA_I, pulse FINISH_O[g] and ERROR_O[g]=ERROR_I for one cycle (one cycle after FINISH_I), go RELEASE.
REQ-013 RELEASE: when BUSY_I=0, clear busy_reg[g], GNT_O, and master-side output registers; go IDLE.
REQ-014 WR_BYTE_NUM_O, WR_DATA_O, RD_BYTE_NUM_O SHALL be stable from ISSUE through RELEASE and zero in IDLE.
REQ-015 Latency: with the FSM in IDLE, START_O SHALL assert 2 cycles after the START_I edge.
REQ-016 Simultaneous requests SHALL be served round-robin; a channel re-requesting immediately SHALL not be served twice before another pending channel.
REQ-017 FINISH_O/ERROR_O SHALL never pulse on a non-granted channel; RD_DATA_O holds its value between FINISH pulses.

Reset
REQ-018 RST_N_I low SHALL asynchronously clear pend, busy_reg, buffers, all outputs to 0, FSM to IDLE, last_gnt to C_CH_NUM-1 (channel 0 first).
REQ-019 Reset mid-transaction SHALL drop the transaction without issuing a FINISH_O or ERROR_O pulse.

Configuration
REQ-020 With IIC_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_BUSY/WAIT_DONE/RELEASE; on reaching C_TIMEOUT_CYC it SHALL pulse FINISH_O[g] and ERROR_O[g] together, clear busy_reg[g] and GNT_O, and return to IDLE.
REQ-021 Without IIC_ARB_TIMEOUT_EN the counter SHALL not exist and the FSM SHALL wait indefinitely.

Verification
REQ-022 Single request: START_I=4'b0010, WR_DATA=64'h11, master BUSY 10 cycles then FINISH -> START_O 2 cycles later, WR_DATA_O=64'h11, GNT_O=0010, FINISH_O[1] one pulse.
REQ-023 Simultaneous START_I=4'b1111 after reset -> grants in order 0,1,2,3, one START_O each.
REQ-024 Fairness: ch0 re-requests immediately after each FINISH while ch2 pending -> order 0,2,0,2.
REQ-025 Error: FINISH_I with ERROR_I=1, RD_DATA_I=64'hDEAD -> FINISH_O[g]=ERROR_O[g]=1 one cycle, RD_DATA_O=64'hDEAD.
REQ-026 Busy-drop: START_I[0] twice while BUSY_O[0]=1 -> exactly one START_O.
REQ-027 Timeout (macro on, C_TIMEOUT_CYC=16): BUSY_I held 1 -> ERROR_O[g] pulses after 16 cycles, FSM IDLE, next pending channel issued.
